// File: rtl/cmd_cfg_gen.sv
// rtl/cmd_cfg_gen.sv - command decode, spin-up/calibration sequencing, emergency landing and link watchdog
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_rdy, cmd, data    command from UART_wrapper (sampled in IDLE only)
//   cal_done              calibration complete from inertial_integrator
//   clr_cmd_rdy           one-cycle pulse, command consumed (RESP)
//   resp, send_resp       0xA5 ACK / 0xEE NAK, valid with the send_resp pulse
//   d_ptch/d_roll/d_yaw   attitude setpoints (signed, passed through)
//   thrst                 thrust setpoint (unsigned)
//   strt_cal              one-cycle pulse at spin-up terminal count
//   inertial_cal          high through SPINUP and CAL
//   motors_off            ESC kill
//   emer_active           emergency landing in progress
module cmd_cfg_gen #(
  parameter int DW       = 16,
  parameter int THR_W    = 9,
  parameter int FAST_SIM = 1,
  parameter int CAL_TMO  = 2**20,
  parameter int LAND_W   = 8,
  parameter int THR_STEP = 4,
  parameter int WD_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_rdy,
  input  logic [7:0]       cmd,
  input  logic [DW-1:0]    data,
  input  logic             cal_done,
  output logic             clr_cmd_rdy,
  output logic [7:0]       resp,
  output logic             send_resp,
  output logic [DW-1:0]    d_ptch,
  output logic [DW-1:0]    d_roll,
  output logic [DW-1:0]    d_yaw,
  output logic [THR_W-1:0] thrst,
  output logic             strt_cal,
  output logic             inertial_cal,
  output logic             motors_off,
  output logic             emer_active
);

  localparam int SPIN_W  = (FAST_SIM != 0) ? 9 : 26;
  localparam int CAL_LIM = (FAST_SIM != 0) ? 1024 : CAL_TMO;
  localparam int CAL_CW  = $clog2(CAL_LIM + 1);
  localparam int WD_EW   = (FAST_SIM != 0) ? 12 : WD_W;

  localparam logic [7:0]        ACK      = 8'hA5;
  localparam logic [7:0]        NAK      = 8'hEE;
  localparam logic [THR_W-1:0]  STEP_C   = THR_W'(THR_STEP);
  localparam logic [CAL_CW-1:0] CAL_LAST = CAL_CW'(CAL_LIM - 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_SPINUP, S_CAL, S_RESP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         resp_q, resp_nxt;
  logic [SPIN_W-1:0]  spin_cnt;
  logic [CAL_CW-1:0]  cal_cnt;
  logic [LAND_W-1:0]  land_cnt;
  logic [WD_EW-1:0]   wd_cnt;

  logic wr_ptch, wr_roll, wr_yaw, wr_thr;
  logic cmd_emer, cmd_kill, spin_go, cal_fail;
  logic thr_ok, accept, wd_run, wd_exp, emer_set, land_tick;
  logic [THR_W-1:0] thr_land;

  // Thrust payload must fit in THR_W bits; anything above is rejected.
  assign thr_ok    = (data >> THR_W) == '0;
  assign accept    = (state == S_IDLE) && cmd_rdy;
  assign wd_run    = !motors_off && (state != S_SPINUP) && (state != S_CAL);
  assign wd_exp    = wd_run && (&wd_cnt);
  assign emer_set  = wd_exp || cmd_emer;
  assign land_tick = emer_active && (&land_cnt);
  assign thr_land  = land_tick ? ((thrst > STEP_C) ? thrst - STEP_C : '0) : thrst;

  assign send_resp    = (state == S_RESP);
  assign clr_cmd_rdy  = (state == S_RESP);
  assign resp         = (state == S_RESP) ? resp_q : 8'h00;
  assign inertial_cal = (state == S_SPINUP) || (state == S_CAL);
  assign strt_cal     = (state == S_SPINUP) && (&spin_cnt);

  always_comb begin
    state_nxt = state;
    resp_nxt  = resp_q;
    wr_ptch   = 1'b0;
    wr_roll   = 1'b0;
    wr_yaw    = 1'b0;
    wr_thr    = 1'b0;
    cmd_emer  = 1'b0;
    cmd_kill  = 1'b0;
    spin_go   = 1'b0;
    cal_fail  = 1'b0;
    case (state)
      S_IDLE: if (cmd_rdy) state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = S_RESP;
        resp_nxt  = NAK;
        case (cmd)
          8'h01: resp_nxt = ACK;
          8'h02: if (!emer_active) begin wr_ptch = 1'b1; resp_nxt = ACK; end
          8'h03: if (!emer_active) begin wr_roll = 1'b1; resp_nxt = ACK; end
          8'h04: if (!emer_active) begin wr_yaw  = 1'b1; resp_nxt = ACK; end
          8'h05: if (!emer_active && thr_ok) begin wr_thr = 1'b1; resp_nxt = ACK; end
          8'h06: if (!emer_active) begin spin_go = 1'b1; state_nxt = S_SPINUP; end
          8'h07: begin cmd_emer = 1'b1; resp_nxt = ACK; end
          8'h08: begin cmd_kill = 1'b1; resp_nxt = ACK; end
          default: ;
        endcase
      end
      S_SPINUP: if (&spin_cnt) state_nxt = S_CAL;
      S_CAL: begin
        // cal_done wins over a coincident timeout
        if (cal_done) begin
          resp_nxt  = ACK;
          state_nxt = S_RESP;
        end else if (cal_cnt == CAL_LAST) begin
          resp_nxt  = NAK;
          cal_fail  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      resp_q      <= 8'h00;
      spin_cnt    <= '0;
      cal_cnt     <= '0;
      land_cnt    <= '0;
      wd_cnt      <= '0;
      d_ptch      <= '0;
      d_roll      <= '0;
      d_yaw       <= '0;
      thrst       <= '0;
      motors_off  <= 1'b1;
      emer_active <= 1'b0;
    end else begin
      state  <= state_nxt;
      resp_q <= resp_nxt;

      spin_cnt <= (state == S_SPINUP) ? spin_cnt + 1'b1 : '0;
      cal_cnt  <= (state == S_CAL)    ? cal_cnt + 1'b1  : '0;

      if (wd_exp || accept)
        wd_cnt <= '0;
      else if (wd_run)
        wd_cnt <= wd_cnt + 1'b1;

      // Tick counter only runs while landing, so a repeated 0x07 keeps its phase.
      land_cnt <= emer_active ? land_cnt + 1'b1 : '0;

      if (emer_active) begin
        thrst <= thr_land;
        if (thr_land == '0) begin
          motors_off  <= 1'b1;
          emer_active <= 1'b0;
        end
      end

      if (wr_ptch) d_ptch <= data;
      if (wr_roll) d_roll <= data;
      if (wr_yaw)  d_yaw  <= data;
      if (wr_thr)  thrst  <= data[THR_W-1:0];
      if (spin_go) motors_off <= 1'b0;
      if (cal_fail) motors_off <= 1'b1;

      // Landing start overrides any attitude write landing on the same edge.
      if (emer_set) begin
        emer_active <= 1'b1;
        d_ptch      <= '0;
        d_roll      <= '0;
        d_yaw       <= '0;
      end

      if (cmd_kill) begin
        motors_off  <= 1'b1;
        emer_active <= 1'b0;
        thrst       <= '0;
      end
    end
  end

endmodule
